heart_hit_detector: RTL and testbench

Consumes the centre/radius outputs of a bouncing ball and the player heart position. Once per animation frame it decides whether the ball circle overlaps the heart's square hitbox and applies damage to player HP, with a frame-counted invulnerability window. It sits between the ball movers and the HUD/game-state logic inside the fighting box.

---
 rtl/heart_hit_detector.sv | 139 +++++++++++++
 tb/tb_heart_hit_detector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/heart_hit_detector.sv
// Per-frame circle-vs-square hit test between the bouncing ball and the player heart.
// Runs a 4-stage evaluation and applies damage with a frame-counted invulnerability window.
module heart_hit_detector #(
    parameter int P_SIZE        = 16,
    parameter int HP_MAX        = 20,
    parameter int DAMAGE        = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic [15:0] i_ball_cx,
    input  logic [15:0] i_ball_cy,
    input  logic [15:0] i_ball_r,
    input  logic [15:0] i_px,
    input  logic [15:0] i_py,
    output logic        o_hit,
    output logic [7:0]  o_hp,
    output logic        o_invuln,
    output logic        o_dead,
    output logic        o_busy
);
    localparam logic [7:0]  L_HP_MAX = 8'(HP_MAX);
    localparam logic [7:0]  L_DMG    = 8'(DAMAGE);
    localparam logic [7:0]  L_INV    = 8'(INVULN_FRAMES);
    localparam logic [16:0] L_SPAN   = 17'(P_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLAMP, S_SQUARE, S_COMPARE, S_APPLY
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cx, r_cy, r_r, r_px, r_py;
    logic [15:0] r_dx, r_dy;
    logic [31:0] r_dx2, r_dy2, r_r2;
    logic        r_overlap;
    logic [7:0]  r_hp;
    logic [7:0]  r_cnt;
    logic        r_hit, r_dead;

    logic        w_frame, w_start, w_apply;
    logic [16:0] w_xhi, w_yhi, w_nx, w_ny, w_dx, w_dy;
    logic [32:0] w_sum;

    assign w_frame = i_ani_stb && i_animate;
    assign w_start = (r_state == S_IDLE) && w_frame && !r_dead;
    assign w_apply = (r_state == S_APPLY) && r_overlap && (r_cnt == 8'd0);

    // Box upper edges kept at 17 bits so a box near 65535 does not wrap.
    assign w_xhi = {1'b0, r_px} + L_SPAN;
    assign w_yhi = {1'b0, r_py} + L_SPAN;

    always_comb begin
        w_nx = {1'b0, r_cx};
        if (r_cx < r_px)             w_nx = {1'b0, r_px};
        else if ({1'b0, r_cx} > w_xhi) w_nx = w_xhi;
        w_ny = {1'b0, r_cy};
        if (r_cy < r_py)             w_ny = {1'b0, r_py};
        else if ({1'b0, r_cy} > w_yhi) w_ny = w_yhi;
        w_dx = ({1'b0, r_cx} >= w_nx) ? ({1'b0, r_cx} - w_nx) : (w_nx - {1'b0, r_cx});
        w_dy = ({1'b0, r_cy} >= w_ny) ? ({1'b0, r_cy} - w_ny) : (w_ny - {1'b0, r_cy});
    end

    assign w_sum = 33'(r_dx2) + 33'(r_dy2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_next = S_CLAMP;
            S_CLAMP:   w_next = S_SQUARE;
            S_SQUARE:  w_next = S_COMPARE;
            S_COMPARE: w_next = S_APPLY;
            S_APPLY:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cx      <= '0;
            r_cy      <= '0;
            r_r       <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_dx2     <= '0;
            r_dy2     <= '0;
            r_r2      <= '0;
            r_overlap <= 1'b0;
        end else begin
            if (w_start) begin
                r_cx <= i_ball_cx;
                r_cy <= i_ball_cy;
                r_r  <= i_ball_r;
                r_px <= i_px;
                r_py <= i_py;
            end
            if (r_state == S_CLAMP) begin
                r_dx <= w_dx[15:0];
                r_dy <= w_dy[15:0];
            end
            if (r_state == S_SQUARE) begin
                r_dx2 <= 32'(r_dx) * 32'(r_dx);
                r_dy2 <= 32'(r_dy) * 32'(r_dy);
                r_r2  <= 32'(r_r) * 32'(r_r);
            end
            if (r_state == S_COMPARE) r_overlap <= (w_sum <= 33'(r_r2));
        end
    end

    // Damage, invulnerability and death; a load from APPLY beats a same-edge decrement.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hp   <= L_HP_MAX;
            r_hit  <= 1'b0;
            r_cnt  <= '0;
            r_dead <= 1'b0;
        end else begin
            r_hit  <= w_apply;
            r_dead <= (r_hp == 8'd0);
            if (w_apply) r_hp <= (r_hp > L_DMG) ? (r_hp - L_DMG) : 8'd0;
            if (w_apply)                          r_cnt <= L_INV;
            else if (w_frame && r_cnt != 8'd0)    r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_hit    = r_hit;
    assign o_hp     = r_hp;
    assign o_invuln = (r_cnt != 8'd0);
    assign o_dead   = r_dead;
    assign o_busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_heart_hit_detector.sv
// Directed bench for heart_hit_detector: geometry vector table plus
// invulnerability, death and mid-evaluation reset sequences.
module tb_heart_hit_detector;
    logic        clk, rst, stb, anim;
    logic [15:0] cx, cy, r, px, py;
    logic        hit, invuln, dead, busy;
    logic [7:0]  hp;

    int checks = 0;
    int errors = 0;

    heart_hit_detector dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(anim),
        .i_ball_cx(cx), .i_ball_cy(cy), .i_ball_r(r), .i_px(px), .i_py(py),
        .o_hit(hit), .o_hp(hp), .o_invuln(invuln), .o_dead(dead), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] px, py, cx, cy, r;
        logic        hit;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    // One frame: strobe for one cycle, then watch 6 edges. Starts just after a posedge.
    task automatic frame(input logic [15:0] fcx, fcy, fr, input logic fanim,
                         output int hits, output int hit_k, output logic busy1,
                         output logic dead4, output logic dead5);
        cx = fcx; cy = fcy; r = fr; anim = fanim; stb = 1'b1;
        hits = 0; hit_k = 0; busy1 = 1'b0; dead4 = 1'b0; dead5 = 1'b0;
        @(posedge clk); #1 stb = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (hit) begin hits++; hit_k = k; end
            if (k == 1) busy1 = busy;
            if (k == 4) dead4 = dead;
            if (k == 5) dead5 = dead;
        end
    endtask

    // Consecutive non-overlapping strobes to run the invulnerability counter down.
    task automatic burn(input int n);
        cx = 16'd0; cy = 16'd0; r = 16'd0; anim = 1'b1; stb = 1'b1;
        repeat (n) @(posedge clk);
        #1 stb = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    vec_t vt[12];
    int   hits, hk, nh;
    logic b1, d4, d5, inv_ok;
    logic [7:0] exp_hp;

    initial begin
        vt[0]  = '{16'd300, 16'd300, 16'd320, 16'd308, 16'd5, 1'b1};
        vt[1]  = '{16'd300, 16'd300, 16'd321, 16'd308, 16'd5, 1'b0};
        vt[2]  = '{16'd300, 16'd300, 16'd319, 16'd319, 16'd5, 1'b0};
        vt[3]  = '{16'd300, 16'd300, 16'd319, 16'd319, 16'd6, 1'b1};
        vt[4]  = '{16'd300, 16'd300, 16'd305, 16'd305, 16'd0, 1'b1};
        vt[5]  = '{16'd300, 16'd300, 16'd315, 16'd300, 16'd0, 1'b1};
        vt[6]  = '{16'd300, 16'd300, 16'd316, 16'd300, 16'd0, 1'b0};
        vt[7]  = '{16'd300, 16'd300, 16'd290, 16'd310, 16'd10, 1'b1};
        vt[8]  = '{16'd300, 16'd300, 16'd295, 16'd295, 16'd7, 1'b0};
        vt[9]  = '{16'd300, 16'd300, 16'd295, 16'd295, 16'd8, 1'b1};
        vt[10] = '{16'd65530, 16'd0, 16'd65535, 16'd5, 16'd0, 1'b1};
        vt[11] = '{16'd300, 16'd300, 16'd1000, 16'd1000, 16'd1000, 1'b1};

        rst = 1'b1; stb = 1'b0; anim = 1'b0;
        cx = '0; cy = '0; r = '0; px = 16'd300; py = 16'd300;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Geometry table, each vector from a fresh reset
        for (int i = 0; i < 12; i++) begin
            pulse_rst();
            px = vt[i].px; py = vt[i].py;
            frame(vt[i].cx, vt[i].cy, vt[i].r, 1'b1, hits, hk, b1, d4, d5);
            chk($sformatf("vec%0d hits", i), hits, vt[i].hit ? 1 : 0);
            chk($sformatf("vec%0d hit_cycle", i), hk, vt[i].hit ? 4 : 0);
            chk($sformatf("vec%0d hp", i), hp, vt[i].hit ? 17 : 20);
            chk($sformatf("vec%0d invuln", i), invuln, vt[i].hit);
            chk($sformatf("vec%0d busy", i), b1, 1);
        end

        // Async reset between edges after a hit
        px = 16'd300; py = 16'd300;
        pulse_rst();
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        chk("pre_rst hp", hp, 17);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        chk("rst hp", hp, 20);
        chk("rst hit", hit, 0);
        chk("rst invuln", invuln, 0);
        chk("rst dead", dead, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Invulnerability window and freeze
        pulse_rst();
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        chk("inv first hit", hits, 1);
        nh = 0; inv_ok = 1'b1;
        for (int f = 0; f < 59; f++) begin
            frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
            nh += hits;
            if (!invuln) inv_ok = 1'b0;
        end
        chk("inv blocked hits", nh, 0);
        chk("inv held", inv_ok, 1);
        chk("inv hp held", hp, 17);
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        chk("inv rehit", hits, 1);
        chk("inv rehit hp", hp, 14);
        cx = 16'd305; cy = 16'd305; r = 16'd2; anim = 1'b0; stb = 1'b1;
        repeat (10) @(posedge clk);
        #1 stb = 1'b0;
        chk("frozen busy", busy, 0);
        chk("frozen invuln", invuln, 1);
        nh = 0;
        for (int f = 0; f < 59; f++) begin
            frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
            nh += hits;
        end
        chk("frozen blocked hits", nh, 0);
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        chk("frozen then hit", hits, 1);
        chk("frozen then hp", hp, 11);

        // Death after seven spaced hits
        pulse_rst();
        exp_hp = 8'd20;
        for (int i = 0; i < 7; i++) begin
            frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
            exp_hp = (exp_hp > 8'd3) ? exp_hp - 8'd3 : 8'd0;
            chk($sformatf("death hit%0d", i), hits, 1);
            chk($sformatf("death hp%0d", i), hp, exp_hp);
            burn(60);
        end
        chk("dead lag", d4, 0);
        chk("dead set", d5, 1);
        chk("dead out", dead, 1);
        chk("dead counter ran", invuln, 0);
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        chk("dead no eval", b1, 0);
        chk("dead no hit", hits, 0);
        chk("dead hp", hp, 0);

        // Reset during SQUARE abandons the evaluation
        pulse_rst();
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        burn(60);
        chk("sq pre hp", hp, 17);
        cx = 16'd305; cy = 16'd305; r = 16'd2; anim = 1'b1; stb = 1'b1;
        @(posedge clk); #1 stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        nh = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (hit) nh++;
        end
        chk("sq no hit", nh, 0);
        chk("sq hp", hp, 20);
        chk("sq idle", busy, 0);
        frame(16'd305, 16'd305, 16'd2, 1'b1, hits, hk, b1, d4, d5);
        chk("sq next hit", hits, 1);
        chk("sq next cycle", hk, 4);
        chk("sq next hp", hp, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
